// File: rtl/bitwise_chk_pkg.sv
// Shared definitions for the bitwise-gate response checker:
// the gate opcode encoding and the checker FSM state type.
package bitwise_chk_pkg;

  localparam logic [1:0] OP_OR  = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOR = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/bitwise_ref_model.sv
// Combinational reference for the gate under test: y = f(op, a, b).
// Kept standalone so the stimulus side can reuse the same golden function.
module bitwise_ref_model
  import bitwise_chk_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the gate function for the current opcode.
  always_comb begin
    y = '0;
    case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/bitwise_resp_checker.sv
// Response checker for a bitwise-gate DUT. Accepts N_VEC (a,b,c) vectors over a
// valid/ready handshake, recomputes c through a two-stage pipe, counts matches
// and mismatches and captures the first failing vector.
// Optional build macro CHK_STOP_ON_FAIL_EN: the first mismatch ends the run early
// (in_ready drops, vectors already in the pipe are still checked).
module bitwise_resp_checker
  import bitwise_chk_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int N_VEC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_c
);

  localparam int ACC_W = $clog2(N_VEC + 1);
  localparam logic [ACC_W-1:0] ACC_N    = ACC_W'(N_VEC);
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(N_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  chk_state_t       state;
  logic [ACC_W-1:0] acc_cnt;
  logic [1:0]       op_q;
  logic             xfer;
  logic             start_ok;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_c;
  logic [WIDTH-1:0] expected;
  logic             mismatch;

  // Ready depends only on state and the accept count, never on in_valid.
  assign in_ready = (state == RUN) && (acc_cnt < ACC_N);
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  bitwise_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .op (op_q),
    .a  (s1_a),
    .b  (s1_b),
    .y  (expected)
  );

  assign mismatch = (s1_c != expected);

  // Run-control FSM: accept count, latched opcode and the busy/done/pass flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc_cnt <= '0;
      op_q    <= OP_OR;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            acc_cnt <= '0;
            op_q    <= op;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        RUN: begin
          if (xfer) begin
            acc_cnt <= acc_cnt + ACC_W'(1);
          end
          if (xfer && (acc_cnt == ACC_LAST)) begin
            state <= DRAIN;
          end
`ifdef CHK_STOP_ON_FAIL_EN
          else if (s1_valid && mismatch) begin
            state <= DRAIN;
          end
`endif
        end
        DRAIN: begin
          if (!s1_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: register each accepted vector for comparison on the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_a <= a;
        s1_b <= b;
        s1_c <= c;
      end
    end
  end

  // Stage 2: score the registered vector, saturate counters, hold the first failure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_cnt    <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_c     <= '0;
    end else if (start_ok) begin
      vec_cnt    <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_c     <= '0;
    end else if (s1_valid) begin
      if (vec_cnt != CNT_MAX) begin
        vec_cnt <= vec_cnt + CNT_W'(1);
      end
      if (mismatch) begin
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_a     <= s1_a;
          fail_b     <= s1_b;
          fail_c     <= s1_c;
        end
      end
    end
  end

endmodule
